// File: rtl/dkong_dma_pkg.sv
// dkong_dma_pkg: shared state encoding, register map and Z80 bus records for the sprite DMA.
package dkong_dma_pkg;
    typedef enum logic [2:0] {IDLE, REQ, RD, WR, NEXT, REL} dma_state_t;
    localparam logic [2:0] REG_SRC_LO = 3'd0;
    localparam logic [2:0] REG_SRC_HI = 3'd1;
    localparam logic [2:0] REG_DST_LO = 3'd2;
    localparam logic [2:0] REG_DST_HI = 3'd3;
    localparam logic [2:0] REG_CNT_LO = 3'd4;
    localparam logic [2:0] REG_CNT_HI = 3'd5;
    localparam logic [2:0] REG_STATUS = 3'd6;
    localparam int STAT_BUSY = 7;
    localparam int STAT_TC   = 6;
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  dmaster;
        logic        rdn;
        logic        wrn;
        logic        inta;
    } z80_master_bus_t;
    typedef struct packed {
        logic [7:0] dslave;
        logic       mwait;
    } z80_slave_bus_t;
endpackage

// File: rtl/dkong_dma_regs.sv
// dkong_dma_regs: CPU-visible source/destination/count registers and STATUS with clear-on-read tc.
module dkong_dma_regs import dkong_dma_pkg::*; #(
    parameter int               CNT_W   = 10,
    parameter logic [15:0]      DEF_SRC = 16'h6900,
    parameter logic [15:0]      DEF_DST = 16'h7000,
    parameter logic [CNT_W-1:0] DEF_CNT = 'h180
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ena_i,
    input  z80_master_bus_t    ibus_i,
    input  logic               busy_i,
    input  logic               tc_set_i,
    output z80_slave_bus_t     obus_o,
    output logic [15:0]        src_o,
    output logic [15:0]        dst_o,
    output logic [CNT_W-1:0]   cnt_o
);
    logic [15:0] src_q, dst_q;
    logic [CNT_W-1:0] cnt_q;
    logic tc_q, rd_stat_q, wr_en, rd_stat;
    logic [7:0] stat;
    assign wr_en   = ena_i && !ibus_i.wrn && !busy_i;
    assign rd_stat = ena_i && !ibus_i.rdn && ibus_i.addr[2:0] == REG_STATUS;
    assign src_o = src_q;
    assign dst_o = dst_q;
    assign cnt_o = cnt_q;
    // tc clears when the STATUS read strobe ends, so a multi-cycle read sees a stable value
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q     <= DEF_SRC;
            dst_q     <= DEF_DST;
            cnt_q     <= DEF_CNT;
            tc_q      <= 1'b0;
            rd_stat_q <= 1'b0;
        end else begin
            rd_stat_q <= rd_stat;
            tc_q      <= tc_set_i || (tc_q && !(rd_stat_q && !rd_stat));
            if (wr_en) begin
                case (ibus_i.addr[2:0])
                    REG_SRC_LO: src_q[7:0]        <= ibus_i.dmaster;
                    REG_SRC_HI: src_q[15:8]       <= ibus_i.dmaster;
                    REG_DST_LO: dst_q[7:0]        <= ibus_i.dmaster;
                    REG_DST_HI: dst_q[15:8]       <= ibus_i.dmaster;
                    REG_CNT_LO: cnt_q[7:0]        <= ibus_i.dmaster;
                    REG_CNT_HI: cnt_q[CNT_W-1:8]  <= ibus_i.dmaster[CNT_W-9:0];
                    default: ;
                endcase
            end
        end
    end
    always_comb begin
        stat            = 8'h00;
        stat[STAT_BUSY] = busy_i;
        stat[STAT_TC]   = tc_q;
        obus_o.mwait    = 1'b1;
        obus_o.dslave   = 8'h00;
        case (ibus_i.addr[2:0])
            REG_SRC_LO: obus_o.dslave = src_q[7:0];
            REG_SRC_HI: obus_o.dslave = src_q[15:8];
            REG_DST_LO: obus_o.dslave = dst_q[7:0];
            REG_DST_HI: obus_o.dslave = dst_q[15:8];
            REG_CNT_LO: obus_o.dslave = cnt_q[7:0];
            REG_CNT_HI: obus_o.dslave = 8'(cnt_q[CNT_W-1:8]);
            REG_STATUS: obus_o.dslave = stat;
            default:    obus_o.dslave = 8'h00;
        endcase
    end
endmodule

// File: rtl/dkong_dma_ctrl.sv
// dkong_dma_ctrl: single-channel bus-master DMA copying sprite RAM to object RAM on each vblank.
module dkong_dma_ctrl import dkong_dma_pkg::*; #(
    parameter int               CNT_W     = 10,
    parameter int               RD_CYCLES = 2,
    parameter int               WR_CYCLES = 2,
    parameter logic [15:0]      DEF_SRC   = 16'h6900,
    parameter logic [15:0]      DEF_DST   = 16'h7000,
    parameter logic [CNT_W-1:0] DEF_CNT   = 'h180
) (
    input  logic            masterclk,
    input  logic            rst,
    input  logic            ena,
    input  z80_master_bus_t ibus,
    output z80_slave_bus_t  obus,
    output z80_master_bus_t dma_bus,
    input  logic [7:0]      dma_din,
    input  logic            dma_wait_n,
    input  logic            drq,
    input  logic            dma_rdy,
    output logic            busrq_n,
    input  logic            busak_n,
    output logic            dma_active,
    output logic            done
);
    localparam logic [7:0] RD_LAST = 8'(RD_CYCLES - 1);
    localparam logic [7:0] WR_LAST = 8'(WR_CYCLES - 1);
    dma_state_t state_q, state_d;
    logic [15:0] src_q, src_d, dst_q, dst_d, reg_src, reg_dst;
    logic [CNT_W-1:0] cnt_q, cnt_d, reg_cnt;
    logic [7:0] cyc_q, cyc_d, data_q, data_d;
    logic drq_q, done_q, tc_set, trig;
    dkong_dma_regs #(.CNT_W(CNT_W), .DEF_SRC(DEF_SRC), .DEF_DST(DEF_DST), .DEF_CNT(DEF_CNT)) u_regs (
        .clk_i(masterclk), .rst_i(rst), .ena_i(ena), .ibus_i(ibus),
        .busy_i(state_q != IDLE), .tc_set_i(tc_set), .obus_o(obus),
        .src_o(reg_src), .dst_o(reg_dst), .cnt_o(reg_cnt)
    );
    assign trig = drq && !drq_q && dma_rdy && state_q == IDLE;
    always_ff @(posedge masterclk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= 16'h0;
            dst_q   <= 16'h0;
            cnt_q   <= '0;
            cyc_q   <= 8'h0;
            data_q  <= 8'h0;
            drq_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            data_q  <= data_d;
            drq_q   <= drq;
            done_q  <= state_d == REL && state_q != REL;
        end
    end
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        data_d  = data_q;
        tc_set  = 1'b0;
        case (state_q)
            IDLE: if (trig) begin
                src_d   = reg_src;
                dst_d   = reg_dst;
                cnt_d   = reg_cnt;
                cyc_d   = 8'h0;
                state_d = reg_cnt == '0 ? REL : REQ;
                tc_set  = reg_cnt == '0;
            end
            REQ: state_d = busak_n ? REQ : RD;
            RD: if (dma_wait_n) begin
                cyc_d   = cyc_q == RD_LAST ? 8'h0 : cyc_q + 8'h1;
                data_d  = cyc_q == RD_LAST ? dma_din : data_q;
                state_d = cyc_q == RD_LAST ? WR : RD;
            end
            WR: if (dma_wait_n) begin
                cyc_d   = cyc_q == WR_LAST ? 8'h0 : cyc_q + 8'h1;
                state_d = cyc_q == WR_LAST ? NEXT : WR;
            end
            NEXT: begin
                src_d   = src_q + 16'h1;
                dst_d   = dst_q + 16'h1;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_d != '0 && dma_rdy) ? RD : REL;
                tc_set  = cnt_d == '0;
            end
            REL: state_d = busak_n ? IDLE : REL;
            default: state_d = IDLE;
        endcase
    end
    assign busrq_n    = !(state_q inside {REQ, RD, WR, NEXT});
    assign dma_active = state_q inside {RD, WR, NEXT};
    assign done       = done_q;
    always_comb begin
        dma_bus.addr    = state_q == RD ? src_q : state_q == WR ? dst_q : 16'h0;
        dma_bus.dmaster = data_q;
        dma_bus.rdn     = state_q != RD;
        dma_bus.wrn     = state_q != WR;
        dma_bus.inta    = 1'b1;
    end
endmodule

// File: tb/tb_dkong_dma_ctrl.sv
// tb_dkong_dma_ctrl: register table, directed corner cases and randomized block copies
// checked against an address/data sequence computed from the transfer parameters.
module tb_dkong_dma_ctrl;
    import dkong_dma_pkg::*;
    localparam int RDC = 2;
    logic masterclk = 1'b0, rst = 1'b1, ena = 1'b0, drq = 1'b0, dma_rdy = 1'b0, busak_n = 1'b1;
    logic busrq_n, dma_active, done, dma_wait_n;
    logic wait_ctl = 1'b1, rand_wait = 1'b0, rand_bit = 1'b1;
    logic [7:0] dma_din;
    z80_master_bus_t ibus, dma_bus;
    z80_slave_bus_t obus;
    int errors = 0, checks = 0, ack_dly = 2, ack_cnt = 0;

    typedef struct packed {logic w; logic [15:0] a; logic [7:0] d;} op_t;
    op_t log_q[$];
    int rd_len_q[$];
    int done_cnt = 0, rq_cycles = 0, rd_starts = 0, rd_run = 0;
    logic prev_rdn = 1'b1, prev_wrn = 1'b1;

    typedef struct {logic w; logic [2:0] a; logic [7:0] d; logic [7:0] exp;} rv_t;
    rv_t tbl[16];

    always #5 masterclk = ~masterclk;

    dkong_dma_ctrl dut (
        .masterclk(masterclk), .rst(rst), .ena(ena), .ibus(ibus), .obus(obus),
        .dma_bus(dma_bus), .dma_din(dma_din), .dma_wait_n(dma_wait_n), .drq(drq),
        .dma_rdy(dma_rdy), .busrq_n(busrq_n), .busak_n(busak_n),
        .dma_active(dma_active), .done(done)
    );

    function automatic logic [7:0] memv(input logic [15:0] a);
        return (a[7:0] * 8'd13) ^ a[15:8] ^ 8'h5A;
    endfunction

    assign dma_din    = memv(dma_bus.addr);
    assign dma_wait_n = rand_wait ? rand_bit : wait_ctl;

    // CPU side: grant the bus ack_dly cycles after the request, release as soon as it drops
    initial forever begin
        @(negedge masterclk);
        rand_bit = $urandom_range(0, 2) != 0;
        ack_cnt  = busrq_n ? 0 : ack_cnt + 1;
        busak_n  = !(ack_cnt >= ack_dly);
    end

    always @(negedge masterclk) begin
        if (!dma_bus.rdn && prev_rdn) begin
            log_q.push_back('{1'b0, dma_bus.addr, 8'h00});
            rd_starts++;
        end
        if (!dma_bus.wrn && prev_wrn) log_q.push_back('{1'b1, dma_bus.addr, dma_bus.dmaster});
        if (!dma_bus.rdn) rd_run++;
        else if (rd_run > 0) begin
            rd_len_q.push_back(rd_run);
            rd_run = 0;
        end
        if (done) done_cnt++;
        if (!busrq_n) rq_cycles++;
        prev_rdn = dma_bus.rdn;
        prev_wrn = dma_bus.wrn;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [7:0] dv);
        @(negedge masterclk);
        ena = 1'b1; ibus.addr = {13'h0, a}; ibus.dmaster = dv; ibus.wrn = 1'b0;
        @(negedge masterclk);
        ena = 1'b0; ibus.wrn = 1'b1;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [7:0] dv);
        @(negedge masterclk);
        ena = 1'b1; ibus.addr = {13'h0, a}; ibus.rdn = 1'b0;
        @(negedge masterclk);
        dv = obus.dslave;
        ena = 1'b0; ibus.rdn = 1'b1;
    endtask

    task automatic prog(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c);
        reg_wr(REG_SRC_LO, s[7:0]); reg_wr(REG_SRC_HI, s[15:8]);
        reg_wr(REG_DST_LO, d[7:0]); reg_wr(REG_DST_HI, d[15:8]);
        reg_wr(REG_CNT_LO, c[7:0]); reg_wr(REG_CNT_HI, c[15:8]);
    endtask

    // Expected bus trace: byte i reads s+i then writes d+i with the byte found at s+i
    task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input int n,
                            input int drop_at, input int stall_at, input bit pokes);
        int ne, lb, rlb, db, qb, sb;
        bit stalled = 0;
        logic [7:0] v;
        logic [15:0] ea;
        prog(s, d, 16'(n));
        dma_rdy = 1'b1;
        lb = log_q.size(); rlb = rd_len_q.size(); db = done_cnt; qb = rq_cycles; sb = rd_starts;
        @(negedge masterclk);
        drq = 1'b1;
        @(negedge masterclk); #1;
        if (n == 0) chk("zero_done_latency", done, 1'b1);
        else chk("busrq_latency", busrq_n, 1'b0);
        for (int c = 0; c < 3000 && done_cnt == db; c++) begin
            if (pokes && c == 4) drq = 1'b0;
            if (pokes && c == 6) begin
                drq = 1'b1;
                reg_wr(REG_SRC_LO, 8'hEE);
            end
            if (drop_at > 0 && rd_starts - sb == drop_at) dma_rdy = 1'b0;
            if (stall_at > 0 && rd_starts - sb == stall_at && !stalled) begin
                wait_ctl = 1'b0;
                repeat (3) @(negedge masterclk);
                wait_ctl = 1'b1;
                stalled = 1;
            end
            @(negedge masterclk); #1;
        end
        chk("done_seen", done_cnt > db, 1'b1);
        drq = 1'b0;
        repeat (20) @(negedge masterclk);
        #1;
        chk("done_once", done_cnt - db, 1);
        chk("bus_released", busrq_n, 1'b1);
        ne = drop_at > 0 ? drop_at : n;
        chk("op_count", log_q.size() - lb, 2 * ne);
        for (int i = 0; i < ne && lb + 2 * i + 1 < log_q.size(); i++) begin
            ea = s + 16'(i);
            chk("rd_op", {log_q[lb+2*i].w, log_q[lb+2*i].a}, {1'b0, ea});
            ea = d + 16'(i);
            chk("wr_op", {log_q[lb+2*i+1].w, log_q[lb+2*i+1].a}, {1'b1, ea});
            chk("wr_data", log_q[lb+2*i+1].d, memv(s + 16'(i)));
        end
        if (n == 0) chk("no_busrq", rq_cycles - qb, 0);
        if (stall_at > 0) chk("stall_rdn_len", rd_len_q[rlb+stall_at-1], RDC + 3);
        reg_rd(REG_STATUS, v);
        chk("status_tc", v, drop_at > 0 ? 8'h00 : 8'h40);
        reg_rd(REG_STATUS, v);
        chk("status_cleared", v, 8'h00);
        if (pokes) begin
            reg_rd(REG_SRC_LO, v);
            chk("busy_write_ignored", v, s[7:0]);
        end
    endtask

    initial begin
        logic [7:0] v;
        ibus = '{addr: 16'h0, dmaster: 8'h0, rdn: 1'b1, wrn: 1'b1, inta: 1'b1};
        tbl = '{
            '{1'b0, 3'd0, 8'h00, 8'h00}, '{1'b0, 3'd1, 8'h00, 8'h69},
            '{1'b0, 3'd2, 8'h00, 8'h00}, '{1'b0, 3'd3, 8'h00, 8'h70},
            '{1'b0, 3'd4, 8'h00, 8'h80}, '{1'b0, 3'd5, 8'h00, 8'h01},
            '{1'b0, 3'd6, 8'h00, 8'h00}, '{1'b0, 3'd7, 8'h00, 8'h00},
            '{1'b1, 3'd0, 8'h34, 8'h00}, '{1'b1, 3'd1, 8'h12, 8'h00},
            '{1'b1, 3'd5, 8'hFF, 8'h00}, '{1'b1, 3'd7, 8'hAA, 8'h00},
            '{1'b0, 3'd0, 8'h00, 8'h34}, '{1'b0, 3'd1, 8'h00, 8'h12},
            '{1'b0, 3'd5, 8'h00, 8'h03}, '{1'b0, 3'd7, 8'h00, 8'h00}
        };
        repeat (3) @(negedge masterclk);
        rst = 1'b0;
        chk("rst_busrq_n", busrq_n, 1'b1);
        chk("rst_active", dma_active, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_strobes", {dma_bus.rdn, dma_bus.wrn}, 2'b11);
        chk("rst_addr", dma_bus.addr, 16'h0);
        chk("rst_dmaster", dma_bus.dmaster, 8'h0);
        foreach (tbl[i]) begin
            if (tbl[i].w) reg_wr(tbl[i].a, tbl[i].d);
            else begin
                reg_rd(tbl[i].a, v);
                chk($sformatf("reg%0d_vec%0d", tbl[i].a, i), v, tbl[i].exp);
            end
        end
        run_xfer(16'h6900, 16'h7000, 4, 0, 0, 1'b1);
        run_xfer(16'hFFFE, 16'h1234, 3, 0, 0, 1'b0);
        run_xfer(16'h4000, 16'h5000, 0, 0, 0, 1'b0);
        run_xfer(16'h2000, 16'h3000, 4, 0, 2, 1'b0);
        run_xfer(16'h8000, 16'h9000, 8, 2, 0, 1'b0);
        rand_wait = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ack_dly = $urandom_range(1, 4);
            run_xfer(16'($urandom), 16'($urandom), $urandom_range(1, 12), 0, 0, 1'b0);
        end
        rand_wait = 1'b0;
        ack_dly = 2;
        prog(16'hA000, 16'hB000, 16'd6);
        dma_rdy = 1'b1;
        @(negedge masterclk);
        drq = 1'b1;
        for (int c = 0; c < 100 && dma_bus.wrn; c++) @(negedge masterclk);
        chk("rst_test_wr_reached", dma_bus.wrn, 1'b0);
        rst = 1'b1;
        drq = 1'b0;
        @(negedge masterclk);
        chk("rst_mid_wrn", dma_bus.wrn, 1'b1);
        chk("rst_mid_rdn", dma_bus.rdn, 1'b1);
        chk("rst_mid_busrq_n", busrq_n, 1'b1);
        chk("rst_mid_active", dma_active, 1'b0);
        rst = 1'b0;
        reg_rd(REG_STATUS, v);
        chk("rst_mid_status", v, 8'h00);
        reg_rd(REG_SRC_HI, v);
        chk("rst_mid_src_hi", v, 8'h69);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
